jtag_dmi_arbiter: RTL and testbench
===================================

JTAG_DMI_ARBITER -- requirements
Module: jtag_dmi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the number of cycles to wait for a DM response before aborting (used only with the configuration macro).
REQ-002 SHALL have port clk, input, 1, the single clock for all state.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rq_valid, input, 2, request valid per requester (bit0 = JTAG DTM, bit1 = system debug host).
REQ-005 SHALL have port rq_ready, output, 2, request accepted per requester.
REQ-006 SHALL have port rq_addr, input, 2 x DMI_ADDR_WIDTH, request address per requester.
REQ-007 SHALL have port rq_wdata, input, 2 x DMI_DATA_WIDTH, request write data per requester.
REQ-008 SHALL have port rq_op, input, 2 x 2, dmi_op_e per requester.
REQ-009 SHALL have port rs_valid, output, 2, response valid per requester.
REQ-010 SHALL have port rs_ready, input, 2, response accepted per requester.
REQ-011 SHALL have port rs_rdata, output, DMI_DATA_WIDTH, response data shared by both requesters.
REQ-012 SHALL have port rs_resp, output, 2, dmi_resp_e shared by both requesters.
REQ-013 SHALL have ports dmi_addr, dmi_wdata, dmi_op and dmi_req_valid as outputs, and dmi_req_ready as input, with widths matching jtag_dmi_pkg; these form the DM request channel.
REQ-014 SHALL have ports dmi_rsp_valid (1), dmi_rdata (DMI_DATA_WIDTH) and dmi_resp (2) as inputs; these form the DM response channel.
REQ-015 SHALL have port grant_id, output, 1, the requester that currently owns the DM.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with one outstanding DM transaction at most.
REQ-018 In IDLE, SHALL grant when any rq_valid is set: if only one is set, grant it; if both are set, grant the requester that was not granted last (round-robin; the last-grant flag resets to 1, so requester 0 wins the first tie).
REQ-019 On grant, SHALL pulse rq_ready[g] for exactly one cycle, latch addr/wdata/op into holding registers, set grant_id = g, and enter ISSUE on the next cycle.
REQ-020 In ISSUE, SHALL drive dmi_req_valid = 1 and dmi_addr/dmi_wdata/dmi_op from the holding registers, held stable until the cycle in which dmi_req_ready = 1, then move to WAIT.
REQ-021 In WAIT, SHALL capture dmi_rdata and dmi_resp on the first cycle in which dmi_rsp_valid = 1, then move to RESP; dmi_rsp_valid in any other state SHALL be ignored.
REQ-022 In RESP, SHALL assert rs_valid[grant_id] only, with rs_rdata/rs_resp stable, until rs_ready[grant_id] = 1; it then returns to IDLE and updates the last-grant flag.
REQ-023 Minimum round trip SHALL be 4 cycles (grant, issue, response capture, response handoff) with zero-wait DM and requester.
REQ-024 A new grant SHALL NOT occur in the same cycle as the return to IDLE; a request pending during a transaction is held by its requester and arbitrated in IDLE.
REQ-025 If rq_valid drops after the grant, the transaction SHALL still complete and the response SHALL still be presented.
REQ-026 rs_valid for the non-granted requester SHALL be 0 at all times.
REQ-027 dmi_op = NOP requests SHALL be forwarded unchanged.

Reset
REQ-028 On rst_n low, all state SHALL reset asynchronously: FSM = IDLE; rq_ready, rs_valid, dmi_req_valid, busy = 0; grant_id = 0; holding and response registers = 0; last-grant flag = 1; timeout counter = 0.
REQ-029 Reset in the middle of a transaction SHALL abandon it without emitting a response; after release, the first tie SHALL go to requester 0.

Configuration
REQ-030 When macro JTAG_DMI_ARB_TIMEOUT_EN is defined, a counter SHALL run in ISSUE and WAIT; on reaching TIMEOUT_CYCLES it SHALL force RESP with rs_resp = 2'b10 (failed) and rs_rdata = 0, drop dmi_req_valid, and ignore any later dmi_rsp_valid for that transaction. The counter SHALL clear on entry to ISSUE.
REQ-031 Without JTAG_DMI_ARB_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL be unbounded; TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-032 Single request: r0 read addr 0x11, DM returns rdata 0xDEADBEEF, resp 0 -> rs_valid[0] with 0xDEADBEEF and resp 0, 4 cycles after rq_valid.
REQ-033 Simultaneous requests: r0 and r1 held valid for 4 transactions -> grant order 0,1,0,1, and each response reaches only its own requester.
REQ-034 Backpressure: dmi_req_ready low for 5 cycles, then rs_ready low for 3 cycles -> DMI outputs and rs_rdata stay stable throughout, and there is no second grant.
REQ-035 Reset asserted in WAIT -> all outputs go to 0 immediately; a late dmi_rsp_valid after release produces no rs_valid.
REQ-036 With JTAG_DMI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, the DM never responds -> rs_resp = 2'b10 and rs_rdata = 0 after 8 WAIT/ISSUE cycles, and the arbiter then returns to IDLE.

Source files
------------

// File: rtl/jtag_dmi_arbiter.sv
// ============================================================================
// Module   : jtag_dmi_arbiter
// Brief    : Round-robin arbiter sharing one DMI port between the JTAG DTM and
//            a system debug host. Optional DM response timeout when the macro
//            JTAG_DMI_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtag_dmi_pkg;
   localparam int DMI_ADDR_WIDTH = 7;
   localparam int DMI_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      DMI_NOP   = 2'd0,
      DMI_READ  = 2'd1,
      DMI_WRITE = 2'd2
   } dmi_op_e;

   typedef enum logic [1:0] {
      DMI_RESP_OK     = 2'd0,
      DMI_RESP_RSVD   = 2'd1,
      DMI_RESP_FAILED = 2'd2,
      DMI_RESP_BUSY   = 2'd3
   } dmi_resp_e;
endpackage

module jtag_dmi_arbiter
   import jtag_dmi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [1:0]                          rq_valid,
   output logic [1:0]                          rq_ready,
   input  logic [1:0][DMI_ADDR_WIDTH-1:0]      rq_addr,
   input  logic [1:0][DMI_DATA_WIDTH-1:0]      rq_wdata,
   input  logic [1:0][1:0]                     rq_op,
   output logic [1:0]                          rs_valid,
   input  logic [1:0]                          rs_ready,
   output logic [DMI_DATA_WIDTH-1:0]           rs_rdata,
   output logic [1:0]                          rs_resp,
   output logic [DMI_ADDR_WIDTH-1:0]           dmi_addr,
   output logic [DMI_DATA_WIDTH-1:0]           dmi_wdata,
   output logic [1:0]                          dmi_op,
   output logic                                dmi_req_valid,
   input  logic                                dmi_req_ready,
   input  logic                                dmi_rsp_valid,
   input  logic [DMI_DATA_WIDTH-1:0]           dmi_rdata,
   input  logic [1:0]                          dmi_resp,
   output logic                                grant_id,
   output logic                                busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e                    r_state;
   logic [1:0]                r_rq_ready;
   logic [1:0]                r_rs_valid;
   logic                      r_dmi_req_valid;
   logic                      r_grant;
   logic                      r_last;
   logic [DMI_ADDR_WIDTH-1:0] r_addr;
   logic [DMI_DATA_WIDTH-1:0] r_wdata;
   logic [1:0]                r_op;
   logic [DMI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                r_resp;

   logic                      w_gnt_any;
   logic                      w_gnt_id;
   logic                      w_timeout;

   // Tie goes to whoever was not served last; a lone request always wins.
   always_comb begin
      w_gnt_any = |rq_valid;
      if (rq_valid == 2'b11)
         w_gnt_id = ~r_last;
      else
         w_gnt_id = rq_valid[1];
   end

`ifdef JTAG_DMI_ARB_TIMEOUT_EN
   localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_cnt_w-1:0] r_tmo_cnt;

   // Fires on the TIMEOUT_CYCLES-th cycle spent in ISSUE/WAIT.
   assign w_timeout = (r_state == S_ISSUE || r_state == S_WAIT) &&
                      (r_tmo_cnt >= c_cnt_w'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
      end else if (r_state == S_IDLE && w_gnt_any) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == S_ISSUE || r_state == S_WAIT) && !w_timeout) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   logic w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_rq_ready      <= 2'b00;
         r_rs_valid      <= 2'b00;
         r_dmi_req_valid <= 1'b0;
         r_grant         <= 1'b0;
         r_last          <= 1'b1;
         r_addr          <= '0;
         r_wdata         <= '0;
         r_op            <= 2'b00;
         r_rdata         <= '0;
         r_resp          <= 2'b00;
      end else begin
         r_rq_ready <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (w_gnt_any) begin
                  r_rq_ready      <= w_gnt_id ? 2'b10 : 2'b01;
                  r_grant         <= w_gnt_id;
                  r_addr          <= rq_addr[w_gnt_id];
                  r_wdata         <= rq_wdata[w_gnt_id];
                  r_op            <= rq_op[w_gnt_id];
                  r_dmi_req_valid <= 1'b1;
                  r_state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (dmi_req_ready) begin
                  r_dmi_req_valid <= 1'b0;
                  r_state         <= S_WAIT;
               end else if (w_timeout) begin
                  r_dmi_req_valid <= 1'b0;
                  r_rdata         <= '0;
                  r_resp          <= DMI_RESP_FAILED;
                  r_rs_valid      <= r_grant ? 2'b10 : 2'b01;
                  r_state         <= S_RESP;
               end
            end
            S_WAIT: begin
               if (dmi_rsp_valid) begin
                  r_rdata    <= dmi_rdata;
                  r_resp     <= dmi_resp;
                  r_rs_valid <= r_grant ? 2'b10 : 2'b01;
                  r_state    <= S_RESP;
               end else if (w_timeout) begin
                  r_rdata    <= '0;
                  r_resp     <= DMI_RESP_FAILED;
                  r_rs_valid <= r_grant ? 2'b10 : 2'b01;
                  r_state    <= S_RESP;
               end
            end
            S_RESP: begin
               // Return to IDLE without re-arbitrating; the next grant is a cycle later.
               if (rs_ready[r_grant]) begin
                  r_rs_valid <= 2'b00;
                  r_last     <= r_grant;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rq_ready      = r_rq_ready;
   assign rs_valid      = r_rs_valid;
   assign rs_rdata      = r_rdata;
   assign rs_resp       = r_resp;
   assign dmi_addr      = r_addr;
   assign dmi_wdata     = r_wdata;
   assign dmi_op        = r_op;
   assign dmi_req_valid = r_dmi_req_valid;
   assign grant_id      = r_grant;
   assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_jtag_dmi_arbiter.sv
// ============================================================================
// Module   : tb_jtag_dmi_arbiter
// Brief    : Directed, table-driven self-checking bench for jtag_dmi_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_dmi_arbiter;
   import jtag_dmi_pkg::*;

   localparam int AW = DMI_ADDR_WIDTH;
   localparam int DW = DMI_DATA_WIDTH;
   localparam int OW = 2 + 2 + 1 + AW + DW + 2 + DW + 2 + 1 + 1;
   localparam int NV = 16;

   logic                 clk;
   logic                 rst_n;
   logic [1:0]           rq_valid;
   logic [1:0]           rq_ready;
   logic [1:0][AW-1:0]   rq_addr;
   logic [1:0][DW-1:0]   rq_wdata;
   logic [1:0][1:0]      rq_op;
   logic [1:0]           rs_valid;
   logic [1:0]           rs_ready;
   logic [DW-1:0]        rs_rdata;
   logic [1:0]           rs_resp;
   logic [AW-1:0]        dmi_addr;
   logic [DW-1:0]        dmi_wdata;
   logic [1:0]           dmi_op;
   logic                 dmi_req_valid;
   logic                 dmi_req_ready;
   logic                 dmi_rsp_valid;
   logic [DW-1:0]        dmi_rdata;
   logic [1:0]           dmi_resp;
   logic                 grant_id;
   logic                 busy;

   int n_cmp = 0;
   int n_bad = 0;

   jtag_dmi_arbiter #(.TIMEOUT_CYCLES(8)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rq_valid      (rq_valid),
      .rq_ready      (rq_ready),
      .rq_addr       (rq_addr),
      .rq_wdata      (rq_wdata),
      .rq_op         (rq_op),
      .rs_valid      (rs_valid),
      .rs_ready      (rs_ready),
      .rs_rdata      (rs_rdata),
      .rs_resp       (rs_resp),
      .dmi_addr      (dmi_addr),
      .dmi_wdata     (dmi_wdata),
      .dmi_op        (dmi_op),
      .dmi_req_valid (dmi_req_valid),
      .dmi_req_ready (dmi_req_ready),
      .dmi_rsp_valid (dmi_rsp_valid),
      .dmi_rdata     (dmi_rdata),
      .dmi_resp      (dmi_resp),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [OW-1:0] obs;
   assign obs = {rq_ready, rs_valid, dmi_req_valid, dmi_addr, dmi_wdata, dmi_op,
                 rs_rdata, rs_resp, grant_id, busy};

   typedef struct {
      logic [1:0]    rqv;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] w0, w1;
      logic [1:0]    o0, o1;
      logic          rdy, rspv;
      logic [DW-1:0] rdata;
      logic [1:0]    resp;
      logic [1:0]    rsr;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t tbl [NV];

   function automatic logic [OW-1:0] ex(logic [1:0] rqr, logic [1:0] rsv, logic dv,
                                        logic [AW-1:0] a, logic [DW-1:0] w, logic [1:0] op,
                                        logic [DW-1:0] rd, logic [1:0] rp, logic gid, logic bz);
      return {rqr, rsv, dv, a, w, op, rd, rp, gid, bz};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply(input vec_t v);
      rq_valid      = v.rqv;
      rq_addr[0]    = v.a0;
      rq_addr[1]    = v.a1;
      rq_wdata[0]   = v.w0;
      rq_wdata[1]   = v.w1;
      rq_op[0]      = v.o0;
      rq_op[1]      = v.o1;
      dmi_req_ready = v.rdy;
      dmi_rsp_valid = v.rspv;
      dmi_rdata     = v.rdata;
      dmi_resp      = v.resp;
      rs_ready      = v.rsr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      rq_valid = '0; rq_addr = '0; rq_wdata = '0; rq_op = '0; rs_ready = '0;
      dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rdata = '0; dmi_resp = '0;

      // One row per clock: inputs applied before the edge, outputs expected after it.
      tbl[0]  = '{2'b01, 7'h11, 7'h00, 32'h0, 32'h0, 2'd1, 2'd0, 1'b1, 1'b0, 32'h0, 2'd0, 2'b00,
                  ex(2'b01, 2'b00, 1'b1, 7'h11, 32'h0, 2'd1, 32'h0, 2'd0, 1'b0, 1'b1)};
      tbl[1]  = '{2'b01, 7'h11, 7'h00, 32'h0, 32'h0, 2'd1, 2'd0, 1'b1, 1'b0, 32'h0, 2'd0, 2'b00,
                  ex(2'b00, 2'b00, 1'b0, 7'h11, 32'h0, 2'd1, 32'h0, 2'd0, 1'b0, 1'b1)};
      tbl[2]  = '{2'b00, 7'h11, 7'h00, 32'h0, 32'h0, 2'd1, 2'd0, 1'b0, 1'b1, 32'hDEADBEEF, 2'd0, 2'b00,
                  ex(2'b00, 2'b01, 1'b0, 7'h11, 32'h0, 2'd1, 32'hDEADBEEF, 2'd0, 1'b0, 1'b1)};
      tbl[3]  = '{2'b00, 7'h11, 7'h00, 32'h0, 32'h0, 2'd1, 2'd0, 1'b0, 1'b0, 32'h0, 2'd0, 2'b01,
                  ex(2'b00, 2'b00, 1'b0, 7'h11, 32'h0, 2'd1, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0)};
      tbl[4]  = '{2'b10, 7'h11, 7'h22, 32'h0, 32'h12345678, 2'd1, 2'd2, 1'b0, 1'b0, 32'h0, 2'd0, 2'b00,
                  ex(2'b10, 2'b00, 1'b1, 7'h22, 32'h12345678, 2'd2, 32'hDEADBEEF, 2'd0, 1'b1, 1'b1)};
      tbl[5]  = '{2'b10, 7'h11, 7'h22, 32'h0, 32'h12345678, 2'd1, 2'd2, 1'b0, 1'b1, 32'h00000BAD, 2'd1, 2'b00,
                  ex(2'b00, 2'b00, 1'b1, 7'h22, 32'h12345678, 2'd2, 32'hDEADBEEF, 2'd0, 1'b1, 1'b1)};
      tbl[6]  = '{2'b00, 7'h11, 7'h22, 32'h0, 32'h12345678, 2'd1, 2'd2, 1'b1, 1'b0, 32'h0, 2'd0, 2'b00,
                  ex(2'b00, 2'b00, 1'b0, 7'h22, 32'h12345678, 2'd2, 32'hDEADBEEF, 2'd0, 1'b1, 1'b1)};
      tbl[7]  = '{2'b00, 7'h11, 7'h22, 32'h0, 32'h12345678, 2'd1, 2'd2, 1'b0, 1'b1, 32'h0, 2'd3, 2'b00,
                  ex(2'b00, 2'b10, 1'b0, 7'h22, 32'h12345678, 2'd2, 32'h0, 2'd3, 1'b1, 1'b1)};
      tbl[8]  = '{2'b00, 7'h11, 7'h22, 32'h0, 32'h12345678, 2'd1, 2'd2, 1'b0, 1'b0, 32'h0, 2'd0, 2'b01,
                  ex(2'b00, 2'b10, 1'b0, 7'h22, 32'h12345678, 2'd2, 32'h0, 2'd3, 1'b1, 1'b1)};
      tbl[9]  = '{2'b00, 7'h11, 7'h22, 32'h0, 32'h12345678, 2'd1, 2'd2, 1'b0, 1'b0, 32'h0, 2'd0, 2'b10,
                  ex(2'b00, 2'b00, 1'b0, 7'h22, 32'h12345678, 2'd2, 32'h0, 2'd3, 1'b1, 1'b0)};
      tbl[10] = '{2'b11, 7'h33, 7'h44, 32'hA5A5A5A5, 32'h0, 2'd0, 2'd1, 1'b0, 1'b0, 32'h0, 2'd0, 2'b00,
                  ex(2'b01, 2'b00, 1'b1, 7'h33, 32'hA5A5A5A5, 2'd0, 32'h0, 2'd3, 1'b0, 1'b1)};
      tbl[11] = '{2'b10, 7'h33, 7'h44, 32'hA5A5A5A5, 32'h0, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0, 2'd0, 2'b00,
                  ex(2'b00, 2'b00, 1'b0, 7'h33, 32'hA5A5A5A5, 2'd0, 32'h0, 2'd3, 1'b0, 1'b1)};
      tbl[12] = '{2'b10, 7'h33, 7'h44, 32'hA5A5A5A5, 32'h0, 2'd0, 2'd1, 1'b0, 1'b1, 32'h1, 2'd0, 2'b00,
                  ex(2'b00, 2'b01, 1'b0, 7'h33, 32'hA5A5A5A5, 2'd0, 32'h1, 2'd0, 1'b0, 1'b1)};
      tbl[13] = '{2'b10, 7'h33, 7'h44, 32'hA5A5A5A5, 32'h0, 2'd0, 2'd1, 1'b0, 1'b0, 32'h0, 2'd0, 2'b01,
                  ex(2'b00, 2'b00, 1'b0, 7'h33, 32'hA5A5A5A5, 2'd0, 32'h1, 2'd0, 1'b0, 1'b0)};
      tbl[14] = '{2'b10, 7'h33, 7'h44, 32'hA5A5A5A5, 32'h0, 2'd0, 2'd1, 1'b0, 1'b0, 32'h0, 2'd0, 2'b00,
                  ex(2'b10, 2'b00, 1'b1, 7'h44, 32'h0, 2'd1, 32'h1, 2'd0, 1'b1, 1'b1)};
      tbl[15] = '{2'b00, 7'h33, 7'h44, 32'hA5A5A5A5, 32'h0, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0, 2'd0, 2'b00,
                  ex(2'b00, 2'b00, 1'b0, 7'h44, 32'h0, 2'd1, 32'h1, 2'd0, 1'b1, 1'b1)};

      repeat (2) @(negedge clk);
      check("reset_state", 128'(obs), 128'(0));
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         apply(tbl[i]);
         step();
         check($sformatf("vec%0d", i), 128'(obs), 128'(tbl[i].exp));
      end

      // Reset while in WAIT: everything clears at once, late response is dropped.
      rst_n = 1'b0;
      #1;
      check("reset_in_wait", 128'(obs), 128'(0));
      rq_valid = 2'b00; rs_ready = 2'b00; dmi_req_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      dmi_rsp_valid = 1'b1;
      dmi_rdata = 32'h55555555;
      for (int i = 0; i < 3; i++) begin
         step();
         check("late_rsp", 128'({rs_valid, busy, rq_ready}), 128'(0));
      end

      // Both requesters held valid, zero-wait DM and requesters.
      rq_valid = 2'b11;
      rq_addr[0] = 7'h01; rq_addr[1] = 7'h02;
      rq_op[0] = 2'd1; rq_op[1] = 2'd1;
      dmi_req_ready = 1'b1; dmi_rsp_valid = 1'b1; dmi_resp = 2'd0;
      rs_ready = 2'b11;
      for (int t = 0; t < 4; t++) begin
         logic [1:0] want;
         want = t[0] ? 2'b10 : 2'b01;
         dmi_rdata = 32'(32'h100 + t);
         n = 0;
         while (rq_ready == 2'b00 && n < 8) begin step(); n++; end
         check("rr_grant", 128'(rq_ready), 128'(want));
         check("rr_gid", 128'(grant_id), 128'(t[0]));
         n = 0;
         while (rs_valid == 2'b00 && n < 8) begin step(); n++; end
         check("rr_rsp", 128'({rs_valid, rs_rdata}), 128'({want, 32'(32'h100 + t)}));
      end
      rq_valid = 2'b00; dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0;
      step();
      rs_ready = 2'b00;

      // Backpressure on both sides with a competing request held pending.
      rq_valid = 2'b11;
      rq_addr[0] = 7'h55; rq_wdata[0] = 32'hCAFEF00D; rq_op[0] = 2'd2;
      rq_addr[1] = 7'h66;
      step();
      check("bp_grant", 128'({rq_ready, grant_id}), 128'({2'b01, 1'b0}));
      rq_addr[0] = 7'h7F; rq_wdata[0] = 32'h0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_issue", 128'({dmi_req_valid, dmi_addr, dmi_wdata, dmi_op, rq_ready}),
               128'({1'b1, 7'h55, 32'hCAFEF00D, 2'd2, 2'b00}));
      end
      dmi_req_ready = 1'b1;
      step();
      check("bp_accept", 128'({dmi_req_valid, busy}), 128'({1'b0, 1'b1}));
      dmi_req_ready = 1'b0;
      dmi_rsp_valid = 1'b1; dmi_rdata = 32'h77777777; dmi_resp = 2'd0;
      step();
      dmi_rsp_valid = 1'b0; dmi_rdata = 32'h0BAD0BAD; dmi_resp = 2'd3;
      for (int i = 0; i < 3; i++) begin
         check("bp_resp", 128'({rs_valid, rs_rdata, rs_resp, rq_ready, busy}),
               128'({2'b01, 32'h77777777, 2'd0, 2'b00, 1'b1}));
         step();
      end
      rs_ready = 2'b01; rq_valid = 2'b00;
      step();
      check("bp_done", 128'({rs_valid, rq_ready, busy}), 128'(0));
      rs_ready = 2'b00;

`ifdef JTAG_DMI_ARB_TIMEOUT_EN
      // DM never answers: failure response forced after 8 ISSUE/WAIT cycles.
      rq_valid = 2'b10; rq_addr[1] = 7'h12;
      step();
      rq_valid = 2'b00;
      for (int i = 1; i < 8; i++) begin
         step();
         check("tmo_pending", 128'({dmi_req_valid, rs_valid}), 128'({1'b1, 2'b00}));
      end
      step();
      check("tmo_fire", 128'({rs_valid, rs_rdata, rs_resp, dmi_req_valid}),
            128'({2'b10, 32'h0, 2'b10, 1'b0}));
      dmi_rsp_valid = 1'b1; dmi_rdata = 32'h1234; dmi_resp = 2'd0;
      step();
      check("tmo_late_rsp", 128'({rs_valid, rs_rdata, rs_resp}), 128'({2'b10, 32'h0, 2'b10}));
      dmi_rsp_valid = 1'b0; rs_ready = 2'b10;
      step();
      check("tmo_idle", 128'({rs_valid, busy}), 128'(0));
      rs_ready = 2'b00;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
